// File: rtl/aes_round_sequencer.sv
// Iterative AES round controller and state register: load pre-round block, run NR rounds, hold result.
// Latency NR edges from accept to out_valid; result held in DONE until out_ready, input stalled meanwhile.
module aes_round_sequencer #(
    parameter int NR = 10,
    parameter int W  = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         mux_sel,
    input  logic [W-1:0] mux_out,
    output logic [W-1:0] state_q,
    output logic [3:0]   round_num,
    output logic         last_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_block
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    localparam logic [3:0] NR_C = 4'(NR);

    fsm_e       fsm_q;
    logic [3:0] round_cnt_q;
    logic [3:0] round_cnt_inc;

    assign round_cnt_inc = round_cnt_q + 4'd1;

    // round_cnt_q is zero outside RUN, so it doubles as the round index output.
    assign round_num = round_cnt_q;
    assign out_block = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            round_cnt_q <= 4'd0;
            state_q     <= '0;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
            mux_sel     <= 1'b0;
            last_round  <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q     <= mux_out;
                        round_cnt_q <= 4'd1;
                        fsm_q       <= RUN;
                        in_ready    <= 1'b0;
                        mux_sel     <= 1'b1;
                        last_round  <= (NR_C == 4'd1);
                    end
                end
                RUN: begin
                    state_q <= mux_out;
                    if (round_cnt_q == NR_C) begin
                        round_cnt_q <= 4'd0;
                        out_valid   <= 1'b1;
                        fsm_q       <= DONE;
                        mux_sel     <= 1'b0;
                        last_round  <= 1'b0;
                    end else begin
                        round_cnt_q <= round_cnt_inc;
                        last_round  <= (round_cnt_inc == NR_C);
                    end
                end
                DONE: begin
                    // in_ready rises only after the output handshake, so no overlap with a new accept.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        fsm_q     <= IDLE;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    fsm_q       <= IDLE;
                    round_cnt_q <= 4'd0;
                    out_valid   <= 1'b0;
                    in_ready    <= 1'b1;
                    mux_sel     <= 1'b0;
                    last_round  <= 1'b0;
                end
            endcase
        end
    end

endmodule
